f_ifu: RTL and testbench

F_IFU -- requirements
Module: f_ifu

---
 rtl/f_ifu_pkg.sv | 22 ++
 rtl/f_npc.sv | 43 ++++
 rtl/f_ifu.sv | 70 +++++++
 tb/tb_f_ifu.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/f_ifu_pkg.sv
// Shared constants and types for the fetch unit: exception vector, exception
// codes, boolean literals and the next-PC source select.
package f_ifu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned EXC_W = 5;

  localparam logic [XLEN-1:0]  EXCPC = 32'h0000_4180;
  localparam logic [EXC_W-1:0] EXCNO = 5'd0;
  localparam logic [EXC_W-1:0] ADEL  = 5'd4;
  localparam logic             TRUE  = 1'b1;
  localparam logic             FALSE = 1'b0;

  typedef enum logic [2:0] {
    NPC_EXC,
    NPC_EPC,
    NPC_HOLD,
    NPC_JUMP,
    NPC_SEQ
  } npc_sel_e;

endpackage

// File: rtl/f_npc.sv
// Combinational next-PC priority mux: exception, ERET, stall, D-stage jump,
// then sequential PC+4.
module f_npc
  import f_ifu_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic            req_i,
  input  logic            eret_i,
  input  logic            block_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] target_i,
  input  logic [XLEN-1:0] epc_i,
  output logic [XLEN-1:0] npc_o
);

  npc_sel_e sel;

  // An ERET waiting behind a stall only takes effect once the stall clears.
  always_comb begin
    sel = NPC_SEQ;
    if (req_i == TRUE) begin
      sel = NPC_EXC;
    end else if ((eret_i == TRUE) && (block_i == FALSE)) begin
      sel = NPC_EPC;
    end else if (block_i == TRUE) begin
      sel = NPC_HOLD;
    end else if (jump_i == TRUE) begin
      sel = NPC_JUMP;
    end
  end

  always_comb begin
    npc_o = pc_i + XLEN'(4);
    case (sel)
      NPC_EXC:  npc_o = EXCPC;
      NPC_EPC:  npc_o = epc_i;
      NPC_HOLD: npc_o = pc_i;
      NPC_JUMP: npc_o = target_i;
      default:  npc_o = pc_i + XLEN'(4);
    endcase
  end

endmodule

// File: rtl/f_ifu.sv
// Instruction fetch unit: PC register, fetch counter and fetch address-error
// check; the next-PC selection lives in f_npc.
module f_ifu
  import f_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] PC_LO    = 32'h0000_3000,
  parameter logic [31:0] PC_HI    = 32'h0000_6FFC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             block,
  input  logic             Req,
  input  logic             D_eret,
  input  logic [XLEN-1:0]  EPC,
  input  logic             D_jump,
  input  logic [XLEN-1:0]  D_target,
  input  logic             D_isCtrl,
  output logic [XLEN-1:0]  i_inst_addr,
  input  logic [XLEN-1:0]  i_inst_rdata,
  output logic [XLEN-1:0]  F_inStr,
  output logic [XLEN-1:0]  F_pc,
  output logic [EXC_W-1:0] F_ExcCode,
  output logic             F_isBD,
  output logic [XLEN-1:0]  fetch_cnt
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cnt_q, cnt_d;
  logic            adel;

  f_npc u_npc (
    .pc_i     (pc_q),
    .req_i    (Req),
    .eret_i   (D_eret),
    .block_i  (block),
    .jump_i   (D_jump),
    .target_i (D_target),
    .epc_i    (EPC),
    .npc_o    (pc_d)
  );

  // A fetch is accepted on any unstalled edge that is not an exception redirect.
  always_comb begin
    cnt_d = cnt_q;
    if ((Req == FALSE) && (block == FALSE)) begin
      cnt_d = cnt_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  assign adel = (pc_q[1:0] != 2'b00) || (pc_q < PC_LO) || (pc_q > PC_HI);

  assign i_inst_addr = pc_q;
  assign F_pc        = pc_q;
  assign F_ExcCode   = adel ? ADEL : EXCNO;
  assign F_inStr     = adel ? '0 : i_inst_rdata;
  assign F_isBD      = D_isCtrl;
  assign fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_f_ifu.sv
// Directed bench for f_ifu: sequential fetch, stalled redirects, exception
// priority, address errors, PC wrap and asynchronous reset.
module tb_f_ifu;
  import f_ifu_pkg::*;

  localparam logic [31:0] IMEM_KEY = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic        block;
  logic        Req;
  logic        D_eret;
  logic [31:0] EPC;
  logic        D_jump;
  logic [31:0] D_target;
  logic        D_isCtrl;
  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;
  logic [31:0] F_inStr;
  logic [31:0] F_pc;
  logic [4:0]  F_ExcCode;
  logic        F_isBD;
  logic [31:0] fetch_cnt;

  int n_checks;
  int n_fail;

  f_ifu dut (
    .clk          (clk),
    .reset        (reset),
    .block        (block),
    .Req          (Req),
    .D_eret       (D_eret),
    .EPC          (EPC),
    .D_jump       (D_jump),
    .D_target     (D_target),
    .D_isCtrl     (D_isCtrl),
    .i_inst_addr  (i_inst_addr),
    .i_inst_rdata (i_inst_rdata),
    .F_inStr      (F_inStr),
    .F_pc         (F_pc),
    .F_ExcCode    (F_ExcCode),
    .F_isBD       (F_isBD),
    .fetch_cnt    (fetch_cnt)
  );

  // Instruction memory: word content derived from its address.
  assign i_inst_rdata = i_inst_addr ^ IMEM_KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; block = 1'b0; Req = 1'b0; D_eret = 1'b0; EPC = '0;
    D_jump = 1'b0; D_target = '0; D_isCtrl = 1'b1;
    step();
    n_checks++;
    if (F_pc !== 32'h0000_3000) begin
      n_fail++; $display("FAIL reset_pc: got %h want %h", F_pc, 32'h0000_3000);
    end
    n_checks++;
    if (fetch_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d want 0", fetch_cnt);
    end
    n_checks++;
    if (F_ExcCode !== 5'd0) begin
      n_fail++; $display("FAIL reset_exc: got %0d want 0", F_ExcCode);
    end
    n_checks++;
    if (F_isBD !== 1'b1) begin
      n_fail++; $display("FAIL reset_isbd: got %b want 1", F_isBD);
    end
    D_isCtrl = 1'b0;
    #1;
    n_checks++;
    if (F_isBD !== 1'b0) begin
      n_fail++; $display("FAIL isbd_follow: got %b want 0", F_isBD);
    end
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    exp_pc = 32'h0000_3000;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (F_pc !== exp_pc) begin
        n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h", i, F_pc, exp_pc);
      end
      n_checks++;
      if (F_inStr !== (exp_pc ^ IMEM_KEY)) begin
        n_fail++; $display("FAIL seq_instr[%0d]: got %h want %h", i, F_inStr, exp_pc ^ IMEM_KEY);
      end
      if (i < 3) step();
      exp_pc = exp_pc + 32'd4;
    end
    n_checks++;
    if (fetch_cnt !== 32'd3) begin
      n_fail++; $display("FAIL seq_cnt: got %0d want 3", fetch_cnt);
    end
  endtask

  task automatic test_jump_stall();
    block = 1'b1; D_jump = 1'b1; D_target = 32'h0000_3100;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (F_pc !== 32'h0000_300C) begin
        n_fail++; $display("FAIL jstall_hold[%0d]: got %h want %h", i, F_pc, 32'h0000_300C);
      end
    end
    n_checks++;
    if (fetch_cnt !== 32'd3) begin
      n_fail++; $display("FAIL jstall_cnt: got %0d want 3", fetch_cnt);
    end
    block = 1'b0;
    step();
    n_checks++;
    if (F_pc !== 32'h0000_3100) begin
      n_fail++; $display("FAIL jstall_target: got %h want %h", F_pc, 32'h0000_3100);
    end
    n_checks++;
    if (fetch_cnt !== 32'd4) begin
      n_fail++; $display("FAIL jstall_cnt2: got %0d want 4", fetch_cnt);
    end
    D_jump = 1'b0;
  endtask

  task automatic test_req_priority();
    D_jump = 1'b1; D_target = 32'h0000_3010;
    step();
    D_jump = 1'b0;
    n_checks++;
    if (F_pc !== 32'h0000_3010) begin
      n_fail++; $display("FAIL req_setup: got %h want %h", F_pc, 32'h0000_3010);
    end
    // Req beats both the stall and a simultaneous ERET.
    Req = 1'b1; block = 1'b1; D_eret = 1'b1; EPC = 32'h0000_3020;
    step();
    Req = 1'b0; block = 1'b0; D_eret = 1'b0;
    n_checks++;
    if (F_pc !== 32'h0000_4180) begin
      n_fail++; $display("FAIL req_pc: got %h want %h", F_pc, 32'h0000_4180);
    end
    n_checks++;
    if (fetch_cnt !== 32'd5) begin
      n_fail++; $display("FAIL req_cnt: got %0d want 5", fetch_cnt);
    end
    n_checks++;
    if (F_ExcCode !== 5'd0) begin
      n_fail++; $display("FAIL req_exc: got %0d want 0", F_ExcCode);
    end
    Req = 1'b1; block = 1'b0;
    step();
    Req = 1'b0;
    n_checks++;
    if (fetch_cnt !== 32'd5) begin
      n_fail++; $display("FAIL req_nocount: got %0d want 5", fetch_cnt);
    end
  endtask

  task automatic test_eret_stall();
    D_eret = 1'b1; EPC = 32'h0000_3020; block = 1'b1;
    step();
    n_checks++;
    if (F_pc !== 32'h0000_4180) begin
      n_fail++; $display("FAIL eret_hold: got %h want %h", F_pc, 32'h0000_4180);
    end
    block = 1'b0;
    step();
    D_eret = 1'b0;
    n_checks++;
    if (F_pc !== 32'h0000_3020) begin
      n_fail++; $display("FAIL eret_pc: got %h want %h", F_pc, 32'h0000_3020);
    end
    n_checks++;
    if (fetch_cnt !== 32'd6) begin
      n_fail++; $display("FAIL eret_cnt: got %0d want 6", fetch_cnt);
    end
  endtask

  task automatic test_adel();
    logic [31:0] tgt   [5];
    logic [4:0]  exp_e [5];
    tgt[0] = 32'h0000_3002; exp_e[0] = 5'd4;
    tgt[1] = 32'h0000_7000; exp_e[1] = 5'd4;
    tgt[2] = 32'h0000_6FFC; exp_e[2] = 5'd0;
    tgt[3] = 32'h0000_2FFC; exp_e[3] = 5'd4;
    tgt[4] = 32'h0000_3000; exp_e[4] = 5'd0;
    for (int i = 0; i < 5; i++) begin
      D_jump = 1'b1; D_target = tgt[i];
      step();
      n_checks++;
      if (F_ExcCode !== exp_e[i]) begin
        n_fail++; $display("FAIL adel_exc[%0d]: got %0d want %0d", i, F_ExcCode, exp_e[i]);
      end
      n_checks++;
      if (F_inStr !== ((exp_e[i] == 5'd4) ? 32'h0 : (tgt[i] ^ IMEM_KEY))) begin
        n_fail++; $display("FAIL adel_instr[%0d]: got %h", i, F_inStr);
      end
    end
    n_checks++;
    if (fetch_cnt !== 32'd11) begin
      n_fail++; $display("FAIL adel_cnt: got %0d want 11", fetch_cnt);
    end
    // Sequential increment past the top of the address space wraps to zero.
    D_target = 32'hFFFF_FFFC;
    step();
    D_jump = 1'b0;
    step();
    n_checks++;
    if (F_pc !== 32'h0000_0000) begin
      n_fail++; $display("FAIL wrap_pc: got %h want 0", F_pc);
    end
    n_checks++;
    if (F_ExcCode !== 5'd4) begin
      n_fail++; $display("FAIL wrap_exc: got %0d want 4", F_ExcCode);
    end
  endtask

  task automatic test_async_reset();
    D_jump = 1'b1; D_target = 32'h0000_3040;
    step();
    n_checks++;
    if (F_pc !== 32'h0000_3040) begin
      n_fail++; $display("FAIL areset_setup: got %h want %h", F_pc, 32'h0000_3040);
    end
    // Leave a stalled redirect pending, then reset between edges.
    D_target = 32'h0000_3100; block = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (F_pc !== 32'h0000_3000) begin
      n_fail++; $display("FAIL areset_pc: got %h want %h", F_pc, 32'h0000_3000);
    end
    n_checks++;
    if (fetch_cnt !== 32'd0) begin
      n_fail++; $display("FAIL areset_cnt: got %0d want 0", fetch_cnt);
    end
    step();
    reset = 1'b0; block = 1'b0; D_jump = 1'b0;
    step();
    n_checks++;
    if (F_pc !== 32'h0000_3004) begin
      n_fail++; $display("FAIL areset_after: got %h want %h", F_pc, 32'h0000_3004);
    end
    n_checks++;
    if (fetch_cnt !== 32'd1) begin
      n_fail++; $display("FAIL areset_cnt2: got %0d want 1", fetch_cnt);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_sequential();
    test_jump_stall();
    test_req_priority();
    test_eret_stall();
    test_adel();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
